// File: rtl/tawas_dram_pkg.sv
// Shared definitions for the data-RAM controller: access size encodings,
// the response-tracking entry, and store/legality helpers.
package tawas_dram_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  // One in-flight access that will produce a load response or an error pulse.
  typedef struct packed {
    logic       valid;
    owner_e     owner;
    logic [1:0] size;
    logic [1:0] offset;
    logic       sgn;
    logic       err;
  } trk_t;

  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: is_illegal = 1'b0;
      SZ_HALF: is_illegal = offset[0];
      SZ_WORD: is_illegal = (offset != 2'b00);
      default: is_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: store_mask = 4'b0001 << offset;
      SZ_HALF: store_mask = offset[1] ? 4'b1100 : 4'b0011;
      default: store_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: store_data = {4{wdata[7:0]}};
      SZ_HALF: store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

endpackage

// File: rtl/dram_load_fmt.sv
// Load formatter: picks the byte/half out of the RAM word and extends it.
module dram_load_fmt
  import tawas_dram_pkg::*;
(
  input  logic [31:0] i_d_dout,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
  always_comb begin
    w_byte = i_d_dout[{i_offset, 3'b000} +: 8];
    w_half = i_offset[1] ? i_d_dout[31:16] : i_d_dout[15:0];
    case (i_size)
      SZ_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
      default: o_data = i_d_dout;
    endcase
  end

endmodule

// File: rtl/dram_ctrl.sv
// Two-port round-robin front end for a single-cycle data RAM: registered RAM
// strobes, store formatting, and a 2-deep tracker returning loads/errors in N+2.
module dram_ctrl
  import tawas_dram_pkg::*;
#(
  parameter int DRAM_AW = 16
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        a_req,
  input  logic        a_wr,
  input  logic [31:0] a_addr,
  input  logic [1:0]  a_size,
  input  logic        a_signed,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  output logic        a_err,

  input  logic        b_req,
  input  logic        b_wr,
  input  logic [31:0] b_addr,
  input  logic [1:0]  b_size,
  input  logic        b_signed,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        b_err,

  output logic [31:0] d_addr,
  output logic        d_cs,
  output logic        d_wr,
  output logic [3:0]  d_mask,
  output logic [31:0] d_din,
  input  logic [31:0] d_dout
);

  logic        r_last_b;
  logic        r_d_cs, r_d_wr;
  logic [31:0] r_d_addr, r_d_din;
  logic [3:0]  r_d_mask;
  trk_t        r_s1, r_s2;

  logic        w_pick_a, w_pick_b, w_accept, w_illegal, w_issue;
  logic        w_wr, w_sgn;
  logic [31:0] w_addr, w_wdata, w_ram_addr, w_load_data;
  logic [1:0]  w_size;
  logic        w_resp_a, w_resp_b;
  trk_t        w_s1_next;

  // r_last_b records the most recent grant; b is preset so a wins the first contention.
  assign w_pick_a = a_req & (~b_req | r_last_b);
  assign w_pick_b = b_req & ~w_pick_a;
  assign w_accept = w_pick_a | w_pick_b;

  always_comb begin
    w_wr    = w_pick_b ? b_wr     : a_wr;
    w_addr  = w_pick_b ? b_addr   : a_addr;
    w_size  = w_pick_b ? b_size   : a_size;
    w_sgn   = w_pick_b ? b_signed : a_signed;
    w_wdata = w_pick_b ? b_wdata  : a_wdata;
  end

  assign w_illegal = is_illegal(w_size, w_addr[1:0]);
  assign w_issue   = w_accept & ~w_illegal;

  // The RAM decodes only the low DRAM_AW bits; the upper bits ride along untouched.
  if (DRAM_AW < 32) begin : g_split_addr
    assign w_ram_addr = {w_addr[31:DRAM_AW], w_addr[DRAM_AW-1:0]};
  end else begin : g_full_addr
    assign w_ram_addr = w_addr;
  end

  always_comb begin
    w_s1_next        = '0;
    w_s1_next.valid  = w_accept & (~w_wr | w_illegal);
    w_s1_next.owner  = w_pick_b ? OWNER_B : OWNER_A;
    w_s1_next.size   = w_size;
    w_s1_next.offset = w_addr[1:0];
    w_s1_next.sgn    = w_sgn;
    w_s1_next.err    = w_illegal;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_b <= 1'b1;
      r_d_cs   <= 1'b0;
      r_d_wr   <= 1'b0;
      r_d_addr <= '0;
      r_d_mask <= '0;
      r_d_din  <= '0;
      r_s1     <= '0;
      r_s2     <= '0;
    end else begin
      if (w_accept) r_last_b <= w_pick_b;
      r_d_cs   <= w_issue;
      r_d_wr   <= w_issue & w_wr;
      r_d_addr <= w_issue ? w_ram_addr : '0;
      r_d_mask <= !w_issue ? 4'b0000 : (w_wr ? store_mask(w_size, w_addr[1:0]) : 4'b1111);
      r_d_din  <= (w_issue & w_wr) ? store_data(w_size, w_wdata) : '0;
      r_s1     <= w_s1_next;
      r_s2     <= r_s1;
    end
  end

  dram_load_fmt u_load_fmt (
    .i_d_dout (d_dout),
    .i_size   (r_s2.size),
    .i_offset (r_s2.offset),
    .i_signed (r_s2.sgn),
    .o_data   (w_load_data)
  );

  assign w_resp_a = r_s2.valid & (r_s2.owner == OWNER_A);
  assign w_resp_b = r_s2.valid & (r_s2.owner == OWNER_B);

  // Acks are the only outputs not sourced from reset flops, so they are gated directly.
  assign a_ack    = w_pick_a & rst_n;
  assign b_ack    = w_pick_b & rst_n;
  assign a_rvalid = w_resp_a & ~r_s2.err;
  assign b_rvalid = w_resp_b & ~r_s2.err;
  assign a_err    = w_resp_a & r_s2.err;
  assign b_err    = w_resp_b & r_s2.err;
  assign a_rdata  = a_rvalid ? w_load_data : '0;
  assign b_rdata  = b_rvalid ? w_load_data : '0;

  assign d_cs   = r_d_cs;
  assign d_wr   = r_d_wr;
  assign d_addr = r_d_addr;
  assign d_mask = r_d_mask;
  assign d_din  = r_d_din;

endmodule

// File: tb/tb_dram_ctrl.sv
// Directed bench for dram_ctrl with a byte-masked single-cycle RAM model.
module tb_dram_ctrl;
  import tawas_dram_pkg::*;

  logic        clk, rst_n;
  logic        a_req, a_wr, a_signed, b_req, b_wr, b_signed;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [1:0]  a_size, b_size;
  logic        a_ack, a_rvalid, a_err, b_ack, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] d_addr, d_din;
  logic        d_cs, d_wr;
  logic [3:0]  d_mask;
  logic [31:0] d_dout = '0;
  logic [31:0] mem [64];

  int n_checks = 0;
  int n_errors = 0;

  dram_ctrl #(.DRAM_AW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_size(a_size), .a_signed(a_signed),
    .a_wdata(a_wdata), .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_size(b_size), .b_signed(b_signed),
    .b_wdata(b_wdata), .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .d_addr(d_addr), .d_cs(d_cs), .d_wr(d_wr), .d_mask(d_mask), .d_din(d_din), .d_dout(d_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (d_cs && d_wr) begin
      for (int i = 0; i < 4; i++)
        if (d_mask[i]) mem[d_addr[7:2]][8*i +: 8] <= d_din[8*i +: 8];
    end
    if (d_cs && !d_wr) d_dout <= mem[d_addr[7:2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one request on port a (pb=0) or b (pb=1) and returns mid N+1 with requests dropped.
  task automatic xact(input bit pb, input bit wr, input logic [31:0] addr, input logic [1:0] size,
                      input bit sgn, input logic [31:0] wdata);
    @(negedge clk);
    if (pb) begin
      b_req = 1'b1; b_wr = wr; b_addr = addr; b_size = size; b_signed = sgn; b_wdata = wdata;
    end else begin
      a_req = 1'b1; a_wr = wr; a_addr = addr; a_size = size; a_signed = sgn; a_wdata = wdata;
    end
    #1;
    check(pb ? "b_ack" : "a_ack", {31'd0, pb ? b_ack : a_ack}, 32'd1);
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    bit          sgn;
    logic [31:0] exp;
  } load_vec_t;

  load_vec_t loads [6] = '{
    '{32'h12, SZ_BYTE, 1'b1, 32'hFFFF_FFFF},
    '{32'h12, SZ_HALF, 1'b0, 32'h0000_80FF},
    '{32'h12, SZ_HALF, 1'b1, 32'hFFFF_80FF},
    '{32'h11, SZ_BYTE, 1'b1, 32'h0000_007F},
    '{32'h13, SZ_BYTE, 1'b0, 32'h0000_0080},
    '{32'h10, SZ_WORD, 1'b0, 32'h80FF_7F01}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    a_req = 0; a_wr = 0; a_addr = '0; a_size = '0; a_signed = 0; a_wdata = '0;
    b_req = 0; b_wr = 0; b_addr = '0; b_size = '0; b_signed = 0; b_wdata = '0;

    // Outputs stay zero under reset even with requests pending.
    @(negedge clk);
    a_req = 1'b1; b_req = 1'b1;
    #1;
    check("rst_a_ack", {31'd0, a_ack}, 32'd0);
    check("rst_b_ack", {31'd0, b_ack}, 32'd0);
    check("rst_d_cs", {31'd0, d_cs}, 32'd0);
    check("rst_d_mask", {28'd0, d_mask}, 32'd0);
    check("rst_a_rdata", a_rdata, 32'd0);
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0; rst_n = 1'b1;

    // Byte store 0xA5 to 0x13.
    xact(0, 1, 32'h13, SZ_BYTE, 0, 32'h0000_00A5);
    check("sb_d_cs", {31'd0, d_cs}, 32'd1);
    check("sb_d_wr", {31'd0, d_wr}, 32'd1);
    check("sb_d_mask", {28'd0, d_mask}, 32'h8);
    check("sb_d_din", d_din, 32'hA5A5_A5A5);
    check("sb_d_addr", d_addr, 32'h13);
    @(negedge clk); #1;
    check("sb_n2_d_cs", {31'd0, d_cs}, 32'd0);
    check("sb_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    check("sb_a_err", {31'd0, a_err}, 32'd0);

    // Word and half stores to set up RAM contents.
    xact(0, 1, 32'h10, SZ_WORD, 0, 32'h80FF_7F01);
    check("sw_d_mask", {28'd0, d_mask}, 32'hF);
    check("sw_d_din", d_din, 32'h80FF_7F01);
    xact(1, 1, 32'h20, SZ_WORD, 0, 32'hCAFE_F00D);
    check("sw_b_d_addr", d_addr, 32'h20);
    xact(1, 1, 32'h32, SZ_HALF, 0, 32'h1234_BEEF);
    check("sh_d_mask", {28'd0, d_mask}, 32'hC);
    check("sh_d_din", d_din, 32'hBEEF_BEEF);
    @(negedge clk); #1;
    check("sh_b_rvalid", {31'd0, b_rvalid}, 32'd0);

    // Load formatting on port a.
    foreach (loads[i]) begin
      xact(0, 0, loads[i].addr, loads[i].size, loads[i].sgn, 32'd0);
      check("ld_d_wr", {31'd0, d_wr}, 32'd0);
      check("ld_d_mask", {28'd0, d_mask}, 32'hF);
      check("ld_n1_rdata", a_rdata, 32'd0);
      @(negedge clk); #1;
      check("ld_a_rvalid", {31'd0, a_rvalid}, 32'd1);
      check("ld_a_rdata", a_rdata, loads[i].exp);
      check("ld_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    end
    xact(1, 0, 32'h32, SZ_HALF, 0, 32'd0);
    @(negedge clk); #1;
    check("ldh_b_rdata", b_rdata, 32'h0000_BEEF);
    check("ldh_a_rvalid", {31'd0, a_rvalid}, 32'd0);

    // Illegal accesses: misaligned word load on b, reserved size store on a.
    xact(1, 0, 32'h22, SZ_WORD, 0, 32'd0);
    check("il_d_cs", {31'd0, d_cs}, 32'd0);
    @(negedge clk); #1;
    check("il_b_err", {31'd0, b_err}, 32'd1);
    check("il_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    check("il_b_rdata", b_rdata, 32'd0);
    check("il_a_err", {31'd0, a_err}, 32'd0);
    xact(0, 1, 32'h10, 2'd3, 0, 32'hDEAD_BEEF);
    check("il3_d_cs", {31'd0, d_cs}, 32'd0);
    @(negedge clk); #1;
    check("il3_a_err", {31'd0, a_err}, 32'd1);
    @(negedge clk); #1;
    check("il3_a_err_clr", {31'd0, a_err}, 32'd0);
    xact(0, 0, 32'h11, SZ_HALF, 0, 32'd0);
    @(negedge clk); #1;
    check("ilh_a_err", {31'd0, a_err}, 32'd1);
    check("ilh_a_rvalid", {31'd0, a_rvalid}, 32'd0);

    // Store then load of the same word on consecutive cycles.
    @(negedge clk);
    a_req = 1'b1; a_wr = 1'b1; a_addr = 32'h40; a_size = SZ_WORD; a_signed = 1'b0; a_wdata = 32'h1234_5678;
    #1; check("sl_st_ack", {31'd0, a_ack}, 32'd1);
    @(negedge clk);
    a_wr = 1'b0;
    #1; check("sl_ld_ack", {31'd0, a_ack}, 32'd1);
    check("sl_st_d_wr", {31'd0, d_wr}, 32'd1);
    check("sl_st_d_din", d_din, 32'h1234_5678);
    @(negedge clk);
    a_req = 1'b0;
    #1; check("sl_ld_d_cs", {31'd0, d_cs}, 32'd1);
    check("sl_ld_d_wr", {31'd0, d_wr}, 32'd0);
    check("sl_n2_rvalid", {31'd0, a_rvalid}, 32'd0);
    @(negedge clk); #1;
    check("sl_rvalid", {31'd0, a_rvalid}, 32'd1);
    check("sl_rdata", a_rdata, 32'h1234_5678);

    // Contention from reset: both ports held for four cycles.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a_req = 1'b1; a_wr = 1'b0; a_addr = 32'h10; a_size = SZ_WORD; a_signed = 1'b0;
    b_req = 1'b1; b_wr = 1'b0; b_addr = 32'h20; b_size = SZ_WORD; b_signed = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 4) begin a_req = 1'b0; b_req = 1'b0; end
      #1;
      if (k < 4) begin
        check($sformatf("rr_a_ack%0d", k), {31'd0, a_ack}, {31'd0, k % 2 == 0});
        check($sformatf("rr_b_ack%0d", k), {31'd0, b_ack}, {31'd0, k % 2 == 1});
      end
      if (k >= 1 && k <= 4) begin
        check($sformatf("rr_d_cs%0d", k), {31'd0, d_cs}, 32'd1);
        check($sformatf("rr_d_addr%0d", k), d_addr, ((k - 1) % 2 == 0) ? 32'h10 : 32'h20);
      end
      if (k >= 2) begin
        check($sformatf("rr_a_rvalid%0d", k), {31'd0, a_rvalid}, {31'd0, (k - 2) % 2 == 0});
        check($sformatf("rr_b_rvalid%0d", k), {31'd0, b_rvalid}, {31'd0, (k - 2) % 2 == 1});
        check($sformatf("rr_a_rdata%0d", k), a_rdata, ((k - 2) % 2 == 0) ? 32'h80FF_7F01 : 32'd0);
        check($sformatf("rr_b_rdata%0d", k), b_rdata, ((k - 2) % 2 == 1) ? 32'hCAFE_F00D : 32'd0);
      end
    end

    // Reset asserted the cycle after a load ack kills the response.
    xact(0, 0, 32'h10, SZ_WORD, 0, 32'd0);
    rst_n = 1'b0;
    a_req = 1'b1;
    #1;
    check("rl_d_cs", {31'd0, d_cs}, 32'd0);
    check("rl_d_addr", d_addr, 32'd0);
    check("rl_d_mask", {28'd0, d_mask}, 32'd0);
    check("rl_a_ack", {31'd0, a_ack}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    a_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rl_a_rvalid%0d", k), {31'd0, a_rvalid}, 32'd0);
      check($sformatf("rl_a_err%0d", k), {31'd0, a_err}, 32'd0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dram_ctrl.md
DRAM_CTRL -- requirements
Module: dram_ctrl

Interface
REQ-001 SHALL have parameter DRAM_AW, default 16, meaning the byte-address width decoded by the attached data RAM (informational; the address passes through unmodified).
REQ-002 SHALL have ports clk (in, 1, clock) and rst_n (in, 1, reset); one clock; reset is asynchronous and active-low.
REQ-003 SHALL have, per requester port p in {a,b}: p_req in 1 (request), p_wr in 1 (1=store), p_addr in 32 (byte address), p_size in 2 (0 byte, 1 half, 2 word, 3 reserved), p_signed in 1 (sign-extend load), p_wdata in 32 (store data, LSB-aligned).
REQ-004 SHALL have, per requester port p: p_ack out 1 (request accepted this cycle), p_rvalid out 1 (load data valid), p_rdata out 32 (load data), p_err out 1 (access rejected).
REQ-005 SHALL have RAM-side ports d_addr out 32, d_cs out 1, d_wr out 1, d_mask out 4 (byte enables), d_din out 32, and d_dout in 32 (RAM read data, valid one cycle after d_cs).

Function
REQ-006 SHALL accept at most one request per cycle; p_ack SHALL be combinational in the cycle of acceptance (cycle N), and the requester holds its request fields until acked.
REQ-007 SHALL arbitrate round-robin: a lone requester wins; with both requesting, the port not granted most recently wins.
REQ-008 SHALL sustain one accepted request per cycle back-to-back with no bubbles.
REQ-009 SHALL register all d_* outputs: an accepted legal request drives d_cs=1 and d_wr=p_wr in cycle N+1 only; d_cs=0 in every other cycle.
REQ-010 SHALL format stores as follows:
- byte: d_mask = 1 << addr[1:0], d_din = byte replicated x4.
- half: d_mask = addr[1] ? 1100 : 0011, d_din = half replicated x2.
- word: d_mask = 1111, d_din = p_wdata.
REQ-011 SHALL drive d_mask=1111 for loads; d_addr SHALL equal the request address.
REQ-012 SHALL, for a legal load, pulse p_rvalid of the owning port for one cycle in N+2, with p_rdata formed combinationally from d_dout:
- select the byte/half at the registered addr[1:0]/addr[1].
- sign-extend if signed, otherwise zero-extend.
- word loads return d_dout unchanged.
REQ-013 SHALL treat as illegal: size 3, half with addr[0]=1, word with addr[1:0]!=0. An illegal request is still acked, issues no RAM access (d_cs=0 in N+1), and pulses p_err of the owner in N+2 with p_rvalid=0.
REQ-014 SHALL produce no rvalid or err for legal stores.
REQ-015 SHALL hold p_rdata at 0 whenever p_rvalid=0.
REQ-016 SHALL correctly handle a store in N+1 followed by a load to the same word in N+2; the load observes the stored data and no extra hazard logic is required.
REQ-017 SHALL keep the tracking pipeline (valid, owner, size, offset, signed, err) 2 entries deep; no stall path exists.

Reset
REQ-018 SHALL, while rst_n=0, force all outputs to 0, clear the pipeline valids, and set the round-robin pointer so that port a wins the first contention.
REQ-019 SHALL discard in-flight requests on reset; no rvalid or err for pre-reset requests SHALL appear after release.
REQ-020 SHALL accept requests in the first cycle after rst_n deasserts.

Structure
REQ-021 SHALL place the size encodings (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2) in shared package tawas_dram_pkg.
REQ-022 SHALL implement load byte-select/extension as sub-module dram_load_fmt (purely combinational, inputs d_dout/size/offset/signed, output 32-bit data); arbitration and pipeline remain in dram_ctrl.

Verification
REQ-023 SHALL cover: a stores byte 0xA5 to addr 0x13 -> d_cs=1, d_wr=1, d_mask=1000, d_din=0xA5A5A5A5 in N+1; a_rvalid/a_err stay 0.
REQ-024 SHALL cover: RAM word at 0x10 = 0x80FF7F01; a signed byte load from 0x12 -> a_rvalid in N+2, a_rdata=0xFFFFFFFF; an unsigned half load from 0x12 -> 0x000080FF.
REQ-025 SHALL cover: a_req and b_req held for 4 cycles from reset -> acks a,b,a,b; loads return in the same order at 2-cycle latency, each on the correct port.
REQ-026 SHALL cover: b word load from 0x22 -> b_ack, d_cs=0 in N+1, b_err pulse in N+2, b_rvalid=0.
REQ-027 SHALL cover: a word store 0x12345678 to 0x40, then a word load from 0x40 next cycle -> a_rdata=0x12345678 in N+3 relative to the store's ack.
REQ-028 SHALL cover: rst_n asserted the cycle after a load ack -> all outputs 0 immediately; no a_rvalid after release.
